// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register/status encodings for the UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// rtl/uart_tx_mmio_fifo.sv - synchronous FIFO with wrapping pointers and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  // Full is judged on the registered count, so a pop in the same cycle never frees a slot early.
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with byte FIFO and status register
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic        re,
  input  logic        reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int BW  = $clog2(CPB);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] CPB_M1 = BW'(CPB - 1);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          push_req, status_wr;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          unused_bits;

  assign push_req  = cs & we & (reg_sel == REG_DATA);
  assign status_wr = cs & we & (reg_sel == REG_STATUS);
  assign busy      = (state_q != IDLE) | ~fifo_empty;
  assign tx        = tx_q;
  assign unused_bits = ^{wdata[31:8], fifo_count};

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .push (push_req),
    .pop  (fifo_pop),
    .wdata(wdata[7:0]),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (push_req && fifo_full) ovf_d = 1'b1;
    else if (status_wr && wdata[0]) ovf_d = 1'b0;
  end

  always_comb begin
    rdata = '0;
    if (cs && re && reg_sel == REG_STATUS) begin
      rdata[ST_EMPTY] = fifo_empty;
      rdata[ST_FULL]  = fifo_full;
      rdata[ST_BUSY]  = busy;
      rdata[ST_OVF]   = ovf_q;
    end
  end

  // tx_d is the line level for the state being entered, so tx stays a plain flop output.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = CPB_M1;
          bit_d    = 3'd0;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          baud_d  = CPB_M1;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = CPB_M1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio (CLKS_PER_BIT = 8)
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, we, re, reg_sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;

  int n_checks = 0;
  int n_fail   = 0;

  logic rec_en = 1'b0;
  logic rec_q[$];
  logic exp_q[$];

  typedef struct {
    logic        cs;
    logic        re;
    logic        reg_sel;
    logic [31:0] exp;
    string       name;
  } rd_vec_t;

  rd_vec_t rd_vecs[6];

  uart_tx_mmio #(
    .CLK_HZ(8),
    .BAUD(1),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .we(we),
    .re(re),
    .reg_sel(reg_sel),
    .wdata(wdata),
    .rdata(rdata),
    .tx(tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rec_en) rec_q.push_back(tx);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cs = 0; we = 0; re = 0; reg_sel = 0; wdata = 0;
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    cs = 1; re = 1; reg_sel = 1;
    #1;
    check32(name, rdata, exp);
    cs = 0; re = 0; reg_sel = 0;
  endtask

  task automatic start_rec();
    rec_q.delete();
    exp_q.delete();
    rec_en = 1'b1;
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 8; i++) exp_q.push_back(b[k]);
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
  endtask

  task automatic wait_rec(input int n, input string name);
    int c = 0;
    while (rec_q.size() < n && c < 5000) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (rec_q.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout, got %0d tx samples expected %0d", name, rec_q.size(), n);
    end
  endtask

  task automatic check_wave(input string name);
    int n = exp_q.size();
    int bad = -1;
    wait_rec(n, name);
    if (rec_q.size() >= n) begin
      for (int i = 0; i < n; i++)
        if (bad < 0 && rec_q[i] !== exp_q[i]) bad = i;
      n_checks++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s: tx sample %0d got %b expected %b", name, bad, rec_q[bad], exp_q[bad]);
      end
    end
  endtask

  // Recording starts one cycle before the first write edge, so the first frame's start bit is sample 2.
  task automatic write_seq(input logic [31:0] w[$]);
    @(posedge clk);
    #1;
    start_rec();
    foreach (w[i]) begin
      cs = 1; we = 1; reg_sel = 0; wdata = w[i];
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  task automatic write_status(input logic [31:0] v);
    cs = 1; we = 1; reg_sel = 1; wdata = v;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    logic [31:0] w[$];

    rd_vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h1, "rd_status"};
    rd_vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0, "rd_data_reg"};
    rd_vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0, "rd_no_cs"};
    rd_vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0, "rd_no_re"};
    rd_vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0, "rd_all_low"};
    rd_vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0, "rd_no_cs_data"};

    idle_inputs();
    reset = 1'b1;
    #12;
    check32("reset_tx", {31'b0, tx}, 32'h1);
    check_status("reset_status", 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (rd_vecs[i]) begin
      cs = rd_vecs[i].cs; re = rd_vecs[i].re; reg_sel = rd_vecs[i].reg_sel; we = 0;
      #1;
      check32(rd_vecs[i].name, rdata, rd_vecs[i].exp);
      idle_inputs();
      #1;
    end

    // Single byte 0xA5
    w = '{32'h0000_00A5};
    write_seq(w);
    push_idle(2); push_frame(8'hA5); push_idle(10);
    wait_rec(40, "single_mid");
    check_status("single_busy", 32'h5);
    check_wave("single_wave");
    check_status("single_done", 32'h1);

    // Back-to-back frames with one idle cycle between
    w = '{32'h41, 32'h42, 32'h43};
    write_seq(w);
    push_idle(2); push_frame(8'h41); push_idle(1); push_frame(8'h42);
    push_idle(1); push_frame(8'h43); push_idle(10);
    wait_rec(244, "b2b_last_stop");
    check_status("b2b_busy_last_stop", 32'h5);
    wait_rec(245, "b2b_after_stop");
    check_status("b2b_done", 32'h1);
    check_wave("b2b_wave");

    // Fill past capacity: 9 accepted, 10th dropped
    w.delete();
    for (int i = 0; i < 10; i++) w.push_back(32'hABCD_0030 + 32'(i));
    write_seq(w);
    check_status("ovf_status", 32'hE);
    write_status(32'h2);
    check_status("ovf_kept", 32'hE);
    write_status(32'h1);
    check_status("ovf_cleared", 32'h6);
    push_idle(2);
    for (int i = 0; i < 9; i++) begin
      push_frame(8'h30 + 8'(i));
      if (i < 8) push_idle(1);
    end
    push_idle(30);
    check_wave("ovf_wave");
    check_status("ovf_done", 32'h1);

    // Reset during bit 3 of the second frame, third byte still queued
    w = '{32'h5A, 32'h35, 32'h77};
    write_seq(w);
    push_idle(2); push_frame(8'h5A); push_idle(1);
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) exp_q.push_back(k[0] ? 1'b0 : 1'b1);
    for (int i = 0; i < 3; i++) exp_q.push_back(1'b0);
    check_wave("rst_pre_wave");
    #1;
    reset = 1'b1;
    #1;
    check32("rst_tx_immediate", {31'b0, tx}, 32'h1);
    rec_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_status("rst_status", 32'h1);
    start_rec();
    push_idle(100);
    check_wave("rst_no_frames");
    check_status("rst_status_end", 32'h1);

    // Upper data bits are ignored
    w = '{32'hFFFF_FF00};
    write_seq(w);
    push_idle(2); push_frame(8'h00); push_idle(5);
    check_wave("upper_bits_wave");
    check_status("upper_bits_done", 32'h1);

    rec_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter peripheral on the CPU data bus, alongside seg7x16 and sw_mem_sel. It consumes store data when io_sel asserts its chip select and buffers bytes in a small FIFO. It serialises each byte as 8N1 on the tx pin and exposes a status word for polling through the read-data mux.

Parameters:
CLK_HZ, 50000000, frequency of clk in Hz.
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, must be >= 2).
FIFO_DEPTH, 8, byte FIFO entries; power of two, >= 2.

Ports:
clk  in  1  system clock (the CPU clock from clk_wiz_0).
reset  in  1  asynchronous, active-high reset.
cs  in  1  chip select from io_sel.
we  in  1  memWrite from the CPU.
re  in  1  memRead from the CPU.
reg_sel  in  1  addr[2]: 0 = DATA register, 1 = STATUS register.
wdata  in  32  Writedata from the CPU.
rdata  out  32  read data to the read-data mux.
tx  out  1  serial line, idle high.

Behaviour:
- Reset (asynchronous, immediate): tx=1, FSM=IDLE, FIFO empty, baud counter=0, bit index=0, overflow=0. Reset mid-frame aborts the frame: tx returns high at once and queued bytes are discarded.
- Push: when cs&we&!reg_sel is high at a clk edge, wdata[7:0] enters the FIFO; wdata[31:8] are ignored.
- Overflow: if the FIFO is full at that edge, the byte is dropped and sticky overflow is set. Full is evaluated before the same-cycle pop, so a push into a full FIFO is rejected even when a pop occurs in that cycle.
- Overflow clear: cs&we&reg_sel with wdata[0]=1 clears overflow. Other STATUS writes have no effect.
- STATUS read (combinational, zero latency): when cs&re&reg_sel, rdata={28'b0, overflow, busy, full, empty}.
  - empty = FIFO count is 0.
  - full = count equals FIFO_DEPTH.
  - busy = FSM!=IDLE or !empty.
- rdata is 0 in all other cases, including DATA reads.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. If the FIFO is non-empty at the edge, pop the head into the shift register, load baud counter=CLKS_PER_BIT-1 and go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles; then shift right and increment bit index. After bit index 7 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
  - Back-to-back: if the FIFO is non-empty, the next START begins one cycle after STOP ends (one IDLE cycle).
  - Frame length: 10*CLKS_PER_BIT cycles plus one IDLE cycle between frames.
- Baud counter: decrements to 0, reloads CLKS_PER_BIT-1 on every state or bit change. It is never free-running.
- Latency: a push into an empty FIFO in an idle peripheral drives tx low 2 edges after the write edge (edge 1: write; edge 2: IDLE pop → START).
- Wrap-around: read and write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits wide.
- Simultaneous push and pop on a non-full FIFO: both occur and count is unchanged.
- tx is registered, with no combinational path from inputs.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, STOP};
  - STATUS bit indices ST_EMPTY=0, ST_FULL=1, ST_BUSY=2, ST_OVF=3;
  - REG_DATA=0, REG_STATUS=1.
- Sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count, async active-high reset) holds the byte buffer. The top level contains the FSM, baud counter and register decode.

Test Plan:
- Single byte: CLK_HZ=8, BAUD=1; write DATA 0x000000A5. tx is low 2 edges later, then emits bits 1,0,1,0,0,1,0,1 for 8 cycles each, then high for 8 cycles. STATUS=0x1 (empty only) afterwards.
- Back-to-back: write 0x41,0x42,0x43 on consecutive cycles. Three frames are sent with exactly one idle cycle between them. STATUS busy=1 until the final STOP ends, then STATUS=0x1.
- Full/overflow: with FIFO_DEPTH=8, write 10 bytes in 10 consecutive cycles. First byte is popped at edge 2, so 9 are accepted; the 10th is dropped. STATUS reads 0xE (overflow, busy, full) right after. Writing STATUS with wdata=1 clears bit 3; only 9 frames appear on tx.
- Read decode: cs=1,re=1,reg_sel=0 gives rdata=0. cs=0,re=1,reg_sel=1 gives rdata=0. cs=1,re=1,reg_sel=1 returns status combinationally in the same cycle.
- Reset mid-frame: assert reset during DATA bit 3 of the second of two queued bytes. tx=1 immediately, STATUS=0x1 after release, and no further frames are sent.
- Ignored upper bits: write 0xFFFFFF00 to DATA. The frame carries 0x00: start bit, eight 0 bits, stop bit.
